// File: rtl/fetch_pc_stage.sv
// Fetch-PC register and IF stage of the RV32I core: selects the next fetch
// address, issues instruction-memory requests and fills the IF/ID register.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branchTaken,
    input  logic [31:0] newpc,
    input  logic        jalrTaken,
    input  logic [31:0] jalrTarget,
    input  logic        stall,
    input  logic        flush,
    input  logic        haltReq,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic        misalignErr,
    output logic        halted
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        HALTED   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        halted_q, halted_d;

    logic        redirect;
    logic [31:0] target;
    logic        transfer;

    // JALR has priority; its bit 0 is dropped before alignment is judged.
    assign redirect = jalrTaken | branchTaken;
    assign target   = jalrTaken ? (jalrTarget & 32'hFFFF_FFFE) : newpc;
    assign transfer = imemReq & imemReady;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so that no path
    // through the case/if leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH:    if (haltReq && !redirect) state_d = HALTED;
            HALTED:   if (redirect) state_d = FETCH;
            default:  state_d = RST_WAIT;
        endcase
    end

    always_comb begin
        imemReq = (state_q == FETCH) & ~stall & ~redirect & ~flush & ~haltReq;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (redirect) begin
            fetch_pc_d = {target[31:2], 2'b00};
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else if (flush) begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else if (stall) begin
            // IF/ID and fetch PC hold their values.
        end else if (transfer) begin
            pc_d       = fetch_pc_q;
            pc_plus4_d = fetch_pc_q + 32'd4;
            instr_d    = imemRdata;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end
        misalign_d = redirect & (target[1:0] != 2'b00);
        halted_d   = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
        end
    end

    assign imemAddr    = fetch_pc_q;
    assign pc          = pc_q;
    assign pcPlus4     = pc_plus4_q;
    assign instr       = instr_q;
    assign instrValid  = valid_q;
    assign misalignErr = misalign_q;
    assign halted      = halted_q;

endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Program-counter register and instruction-fetch stage of the RV32I core. It holds the fetch PC and issues instruction-memory requests. It selects the next PC from three sources: sequential pc+4, the branch/JAL target produced by the PC-target adder (`newpc`), or a JALR target. Fetched instructions are registered into the IF/ID pipeline register, which supports stall, flush and halt, for consumption by decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on `instr` when no valid instruction is present (addi x0,x0,0)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- branchTaken  in  1  redirect to `newpc` (branch taken or JAL), from EX
- newpc  in  32  branch/JAL target, pc+immExt from the PC-target adder
- jalrTaken  in  1  redirect to `jalrTarget`, from EX
- jalrTarget  in  32  rs1+imm; bit 0 is cleared inside this block
- stall  in  1  hazard unit request to freeze fetch and IF/ID
- flush  in  1  invalidate IF/ID without a redirect
- haltReq  in  1  stop fetching (EBREAK/ECALL seen in decode)
- imemReq  out  1  fetch request valid
- imemAddr  out  32  fetch address; equals fetchPc
- imemReady  in  1  memory accepts the request; `imemRdata` is valid in the same cycle
- imemRdata  in  32  instruction word
- pc  out  32  IF/ID PC of the held instruction
- pcPlus4  out  32  IF/ID pc+4, used for JAL/JALR link
- instr  out  32  IF/ID instruction
- instrValid  out  1  IF/ID valid
- misalignErr  out  1  one-cycle pulse: redirect target was not word aligned
- halted  out  1  block is in HALTED state

## Operation
- **redirect** = `jalrTaken | branchTaken`.
- **target:** `{jalrTarget[31:1],1'b0}` when `jalrTaken`, else `newpc`. `jalrTaken` has priority when both are high.
- **FSM states:**
  - RST_WAIT: entered on reset; lasts exactly 1 cycle after `rst` falls; `imemReq`=0; then FETCH.
  - FETCH: normal operation.
  - HALTED: entered from FETCH on `haltReq` with no redirect; leaves only on a redirect, which returns to FETCH with `fetchPc`=target.
- **imemReq** = (state==FETCH) & ~stall & ~redirect & ~flush & ~haltReq. This path is combinational.
- **transfer** = `imemReq & imemReady`. On transfer:
  - `pc`←fetchPc
  - `pcPlus4`←fetchPc+4
  - `instr`←imemRdata
  - `instrValid`←1
  - fetchPc←fetchPc+4
- **Priority each cycle, highest first:**
  1. redirect: fetchPc←{target[31:2],2'b00}; `instrValid`←0; `instr`←NOP_INSTR. Stall is ignored.
  2. flush: `instrValid`←0, `instr`←NOP_INSTR; fetchPc unchanged.
  3. stall: IF/ID and fetchPc hold. No request is issued.
  4. transfer: capture as above.
  5. otherwise (memory not ready, RST_WAIT, HALTED, or haltReq): `instrValid`←0, `instr`←NOP_INSTR; fetchPc holds.
- **misalignErr:** registered; set for one cycle when a redirect's target[1:0] != 0. The PC is still redirected, with the low bits cleared.
- **Arithmetic:** all adds are modulo 2^32. 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.

## Timing
- **Reset values (asynchronous):**
  - state=RST_WAIT, fetchPc=RESET_PC, `imemAddr`=RESET_PC, `imemReq`=0
  - `pc`=0, `pcPlus4`=0, `instr`=NOP_INSTR, `instrValid`=0
  - `misalignErr`=0, `halted`=0
- **First request:** `imemReq` goes high in the second cycle after `rst` falls.
- **Fetch latency:** an instruction transferred in cycle N appears on `instr`/`instrValid` in cycle N+1.
- **Throughput:** with `imemReady` tied high, no stall and no redirect, throughput is one instruction per cycle.
- **Redirect:** redirect asserted in cycle N gives `imemAddr`=target and `instrValid`=0 in cycle N+1. The target instruction is valid in IF/ID in cycle N+2.
- **Reset mid-operation:** asserting `rst` in any state clears everything immediately, including a pending `misalignErr` pulse.
- **`halted`** is a registered output; it is high in every cycle in which the state is HALTED.

## Test plan
- **Reset/sequential:** release `rst` with RESET_PC=0 and `imemReady`=1. Expect `imemReq` low for 1 cycle, then `imemAddr` 0,4,8,… Expect `pc`/`instr` to follow one cycle later, and `pcPlus4` = `pc`+4.
- **Branch redirect with simultaneous stall:** in the cycle `imemAddr`=0x10, set `branchTaken`=1, `newpc`=0x100 and `stall`=1. Expect `imemReq`=0 that cycle, `imemAddr`=0x100 next cycle, `instrValid`=0 for one cycle, then `pc`=0x100.
- **JALR vs branch priority:** assert `jalrTaken`=1 with `jalrTarget`=0x203, together with `branchTaken`=1 and `newpc`=0x40. Expect `imemAddr`=0x200 and `misalignErr` pulsed for 1 cycle.
- **Memory wait and stall hold:**
  - hold `imemReady`=0 for 3 cycles at addr 0x20; expect `instrValid`=0 and `imemAddr` stable at 0x20.
  - stall for 2 cycles while valid; expect IF/ID unchanged and `imemReq`=0.
- **Halt/resume:** assert `haltReq`; expect `halted`=1 and `imemReq`=0 indefinitely. Then redirect to 0x80; expect FETCH state and `imemAddr`=0x80.
- **Wrap-around and async reset:** redirect to 0xFFFF_FFFC; expect the next address 0x0000_0000. Assert `rst` mid-stream; expect all outputs at reset values before the next clock edge.
